piano_key_detector: RTL and testbench
=====================================

# piano_key_detector

Frame-rate stage directly downstream of the colour-finger tracker. Samples the tracker's per-frame `center_x`/`center_y` once per frame and maps the point onto a row of virtual piano keys. Debounces the key over consecutive frames and emits registered `note_on` / `note_off` pulses plus a held-key status for the tone/sound stage.

## Interface
Parameters:
- `NUM_KEYS`, 8: number of keys, 1..15.
- `KEY_X0`, 0: left edge of key 0, in pixels.
- `KEY_W`, 80: key width, in pixels.
- `KEY_Y_TOP`, 240: top of the keyboard zone, inclusive.
- `KEY_Y_BOT`, 479: bottom of the keyboard zone, inclusive.
- `PRESS_FRAMES`, 3: consecutive same-key frames needed to press; must be ≥2.
- `RELEASE_FRAMES`, 2: consecutive non-matching frames needed to release; must be ≥1.

Ports:
- `clk` input 1: pixel clock, same domain as the tracker.
- `reset` input 1: asynchronous, active-high.
- `vsync` input 1: camera vsync, the same net the tracker sees.
- `center_x` input 10: tracker output, stable between frame ends.
- `center_y` input 10: tracker output.
- `key_active` output 1: a key is currently held.
- `key_idx` output 4: index of the held key; 0 when none is held.
- `note_on` output 1: one-cycle pulse when a press is accepted.
- `note_off` output 1: one-cycle pulse when a release is accepted.
- `note_key` output 4: key number for the latest pulse; holds its value between pulses.

## Operation
- Frame end is the cycle N where `vsync_d && !vsync` (vsync falling edge). `vsync_d` resets to 0, so no spurious edge occurs after reset.
- The sample cycle is S = N+1, because the tracker's centre registers update at the end of cycle N.
- Zone decode at S (combinational):
  - A key is valid when `KEY_Y_TOP ≤ y ≤ KEY_Y_BOT` and `KEY_X0 ≤ x < KEY_X0 + NUM_KEYS*KEY_W`.
  - Key k is chosen when `KEY_X0 + k*KEY_W ≤ x < KEY_X0 + (k+1)*KEY_W`.
  - Decode uses a comparator chain, not a divider. All compares are 11-bit unsigned; parameter products are computed at elaboration.
  - Anything outside the zone decodes to NONE. The tracker's reset value (0,0) falls outside the zone by default.
- FSM (`cand`, `cnt` are 4-bit; all transitions happen only at sample cycles):
  - IDLE: valid key k → ARMING, `cand=k`, `cnt=1`. NONE → stay in IDLE.
  - ARMING:
    - Same `cand`: `cnt+1`. When it reaches `PRESS_FRAMES` → HELD, fire `note_on`, `note_key=cand`, `key_active=1`, `key_idx=cand`.
    - Different valid key: `cand` = new key, `cnt=1`.
    - NONE → IDLE.
  - HELD:
    - Same key → stay.
    - Otherwise → miss with `cnt=1`. If `RELEASE_FRAMES==1`, release immediately; else go to RELEASING.
  - RELEASING:
    - Held key seen again → HELD, cancel the release, no pulse.
    - Otherwise `cnt+1`. When it reaches `RELEASE_FRAMES`, release.
  - Release actions: fire `note_off`, `note_key` = held key, `key_active=0`, `key_idx=0`. The next state is ARMING (`cand` = sampled key, `cnt=1`) if the sample was a valid key, else IDLE.
- `note_on` and `note_off` never fire in the same cycle. A key change always produces `note_off`, then at least `PRESS_FRAMES-1` further frames before `note_on`.

## Timing
- Every output resets to 0; state resets to IDLE; `cand`, `cnt` and `vsync_d` reset to 0.
- Latency: a frame end in cycle N gives a registered output update in cycle N+2. Pulses are high exactly in cycle N+2.
- Cycles other than S never change state or outputs.
- Reset mid-hold clears everything asynchronously and emits no `note_off`.
- Centre values that change while the sample is pending are irrelevant: only the value present at S is used.

## Structure
- Package `piano_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} pkd_state_t`;
  - `typedef logic [3:0] key_t`;
  - `KEY_NONE = 4'hF`, the decoder's no-key code and never a valid index.
- Sub-module `key_zone_decoder`: parameterised combinational x/y → `key_t` mapping, reusable by the on-screen keyboard overlay.
- The top level holds the edge detector, sample strobe, FSM and output registers.

## Test plan
- Press: reset, then centre (200,300) for 3 frames → `note_on` for one cycle at N+2 of frame 3, `note_key=2`, `key_idx=2`, `key_active=1`.
- Short press: centre (200,300) for 2 frames, then (200,100) → no pulse, FSM ends in IDLE, outputs stay 0.
- Glitch: key 2 held, 1 frame at (600,300) (key 7), then key 2 again → no `note_off`, `key_idx` stays 2.
- Slide: key 2 held, then (280,300) for 5 frames → `note_off` with `note_key=2` on frame 2; `note_on` with `note_key=3` on frame 4.
- Boundaries:
  - x=79 → key 0; x=80 → key 1; x=640 → NONE.
  - y=239 → NONE; y=240 → valid key; y=479 → valid key.
- Reset mid-hold: assert `reset` while key 5 is held → all outputs 0 immediately, no pulse. After release, vsync already low → no sample until the next real falling edge.

Source files
------------

// File: rtl/piano_key_detector_pkg.sv
// Shared types and helpers for the piano key detector and the keyboard overlay.
package piano_pkg;

    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} pkd_state_t;

    typedef logic [3:0] key_t;

    // Decoder code for "no key"; never a valid key index.
    localparam key_t KEY_NONE = 4'hF;

    // Unsigned 11-bit a >= b, taken from the borrow of a 12-bit subtraction.
    // This keeps compares against zero-valued parameters free of constant-compare folding.
    function automatic logic u11_ge(input logic [10:0] a, input logic [10:0] b);
        logic [11:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return !diff[11];
    endfunction

endpackage

// File: rtl/key_zone_decoder.sv
// Combinational mapping of a screen point onto a row of virtual keys.
module key_zone_decoder
    import piano_pkg::*;
#(
    parameter int NUM_KEYS  = 8,
    parameter int KEY_X0    = 0,
    parameter int KEY_W     = 80,
    parameter int KEY_Y_TOP = 240,
    parameter int KEY_Y_BOT = 479
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output key_t       key
);

    localparam logic [10:0] X_LO    = 11'(KEY_X0);
    localparam logic [10:0] Y_LO    = 11'(KEY_Y_TOP);
    localparam logic [10:0] Y_HI_EX = 11'(KEY_Y_BOT + 1);

    logic [10:0]         x11;
    logic [10:0]         y11;
    logic [NUM_KEYS-1:0] below_edge;
    logic                in_zone;

    assign x11 = {1'b0, x};
    assign y11 = {1'b0, y};

    // below_edge[k]: x lies left of the right edge of key k (edges fixed at elaboration).
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_edge
        localparam logic [10:0] EDGE = 11'(KEY_X0 + (k + 1) * KEY_W);
        assign below_edge[k] = !u11_ge(x11, EDGE);
    end

    // Zone gate, then pick the lowest key whose right edge is still to the right of x.
    always_comb begin
        key     = KEY_NONE;
        in_zone = u11_ge(y11, Y_LO) && !u11_ge(y11, Y_HI_EX) && u11_ge(x11, X_LO);
        if (in_zone) begin
            for (int k = NUM_KEYS - 1; k >= 0; k--) begin
                if (below_edge[k]) key = 4'(k);
            end
        end
    end

endmodule

// File: rtl/piano_key_detector.sv
// Frame-rate key detector: samples the tracker centre once per frame,
// debounces the decoded key and issues note_on / note_off pulses.
module piano_key_detector
    import piano_pkg::*;
#(
    parameter int NUM_KEYS       = 8,
    parameter int KEY_X0         = 0,
    parameter int KEY_W          = 80,
    parameter int KEY_Y_TOP      = 240,
    parameter int KEY_Y_BOT      = 479,
    parameter int PRESS_FRAMES   = 3,
    parameter int RELEASE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic [9:0] center_x,
    input  logic [9:0] center_y,
    output logic       key_active,
    output logic [3:0] key_idx,
    output logic       note_on,
    output logic       note_off,
    output logic [3:0] note_key
);

    key_t       zone_key;
    logic       vsync_prev_q, vsync_prev_d;
    logic       sample_q, sample_d;
    pkd_state_t state_q, state_d;
    key_t       cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic       key_active_q, key_active_d;
    key_t       key_idx_q, key_idx_d;
    logic       note_on_q, note_on_d;
    logic       note_off_q, note_off_d;
    key_t       note_key_q, note_key_d;
    logic [3:0] cnt_inc;
    logic       do_release;

    key_zone_decoder #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_X0   (KEY_X0),
        .KEY_W    (KEY_W),
        .KEY_Y_TOP(KEY_Y_TOP),
        .KEY_Y_BOT(KEY_Y_BOT)
    ) u_decoder (
        .x  (center_x),
        .y  (center_y),
        .key(zone_key)
    );

    // Frame end is the vsync falling edge; the centre is sampled one cycle later,
    // once the tracker has registered its final value for the frame.
    always_comb begin
        vsync_prev_d = vsync;
        sample_d     = vsync_prev_q && !vsync;
    end

    // Debounce FSM and output next-state; only the sample cycle may change anything.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        key_active_d = key_active_q;
        key_idx_d    = key_idx_q;
        note_on_d    = 1'b0;
        note_off_d   = 1'b0;
        note_key_d   = note_key_q;
        do_release   = 1'b0;
        cnt_inc      = cnt_q + 4'd1;

        if (sample_q) begin
            case (state_q)
                IDLE: begin
                    if (zone_key != KEY_NONE) begin
                        state_d = ARMING;
                        cand_d  = zone_key;
                        cnt_d   = 4'd1;
                    end
                end
                ARMING: begin
                    if (zone_key == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(PRESS_FRAMES)) begin
                            state_d      = HELD;
                            note_on_d    = 1'b1;
                            note_key_d   = cand_q;
                            key_active_d = 1'b1;
                            key_idx_d    = cand_q;
                        end
                    end else if (zone_key != KEY_NONE) begin
                        cand_d = zone_key;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (zone_key != key_idx_q) begin
                        cnt_d = 4'd1;
                        if (RELEASE_FRAMES == 1) do_release = 1'b1;
                        else                     state_d    = RELEASING;
                    end
                end
                RELEASING: begin
                    if (zone_key == key_idx_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == 4'(RELEASE_FRAMES)) do_release = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            // A release restarts arming from the frame that caused it.
            if (do_release) begin
                note_off_d   = 1'b1;
                note_key_d   = key_idx_q;
                key_active_d = 1'b0;
                key_idx_d    = 4'd0;
                if (zone_key != KEY_NONE) begin
                    state_d = ARMING;
                    cand_d  = zone_key;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // State and output registers; reset clears everything without a pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_q <= 1'b0;
            sample_q     <= 1'b0;
            state_q      <= IDLE;
            cand_q       <= 4'd0;
            cnt_q        <= 4'd0;
            key_active_q <= 1'b0;
            key_idx_q    <= 4'd0;
            note_on_q    <= 1'b0;
            note_off_q   <= 1'b0;
            note_key_q   <= 4'd0;
        end else begin
            vsync_prev_q <= vsync_prev_d;
            sample_q     <= sample_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_active_q <= key_active_d;
            key_idx_q    <= key_idx_d;
            note_on_q    <= note_on_d;
            note_off_q   <= note_off_d;
            note_key_q   <= note_key_d;
        end
    end

    assign key_active = key_active_q;
    assign key_idx    = key_idx_q;
    assign note_on    = note_on_q;
    assign note_off   = note_off_q;
    assign note_key   = note_key_q;

endmodule

// File: tb/tb_piano_key_detector.sv
// Directed bench for piano_key_detector with a frame-level reference model.
module tb_piano_key_detector;

    localparam int NUM_KEYS = 8;
    localparam int X0       = 0;
    localparam int W        = 80;
    localparam int YTOP     = 240;
    localparam int YBOT     = 479;
    localparam int PRESS    = 3;
    localparam int REL      = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [9:0] center_x = '0;
    logic [9:0] center_y = '0;
    logic       key_active;
    logic [3:0] key_idx;
    logic       note_on;
    logic       note_off;
    logic [3:0] note_key;

    int total = 0;
    int bad   = 0;
    int on_cnt  = 0;
    int off_cnt = 0;

    piano_key_detector #(
        .NUM_KEYS(NUM_KEYS), .KEY_X0(X0), .KEY_W(W),
        .KEY_Y_TOP(YTOP), .KEY_Y_BOT(YBOT),
        .PRESS_FRAMES(PRESS), .RELEASE_FRAMES(REL)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync),
        .center_x(center_x), .center_y(center_y),
        .key_active(key_active), .key_idx(key_idx),
        .note_on(note_on), .note_off(note_off), .note_key(note_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode by plain division; 15 means no key.
    function automatic int mkey(input int x, input int y);
        if (y < YTOP || y > YBOT) return 15;
        if (x < X0 || x >= X0 + NUM_KEYS * W) return 15;
        return (x - X0) / W;
    endfunction

    // Frame-level model: a run of identical keys presses, a run of misses releases.
    int held = -1, cand = 0, streak = 0, miss = 0;
    int e_on = 0, e_off = 0, e_key = 0;
    int vs_prev = 0, pend = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            held = -1; cand = 0; streak = 0; miss = 0;
            e_on = 0; e_off = 0; e_key = 0; vs_prev = 0; pend = 0;
        end else begin
            int k;
            int do_s;
            do_s    = pend;
            pend    = (vs_prev == 1 && vsync == 1'b0) ? 1 : 0;
            vs_prev = int'(vsync);
            e_on  = 0;
            e_off = 0;
            if (do_s != 0) begin
                k = mkey(int'(center_x), int'(center_y));
                if (held < 0) begin
                    if (k == 15) streak = 0;
                    else if (streak > 0 && k == cand) streak++;
                    else begin cand = k; streak = 1; end
                    if (streak == PRESS) begin
                        held = cand; e_on = 1; e_key = cand; streak = 0;
                    end
                end else if (k == held) begin
                    miss = 0;
                end else begin
                    miss++;
                    if (miss == REL) begin
                        e_off = 1; e_key = held; held = -1; miss = 0;
                        if (k != 15) begin cand = k; streak = 1; end
                        else streak = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus pulse counters.
    always @(negedge clk) begin
        chk("key_active", int'(key_active), (held >= 0) ? 1 : 0);
        chk("key_idx",    int'(key_idx),    (held >= 0) ? held : 0);
        chk("note_on",    int'(note_on),    e_on);
        chk("note_off",   int'(note_off),   e_off);
        chk("note_key",   int'(note_key),   e_key);
        if (note_on)  on_cnt++;
        if (note_off) off_cnt++;
    end

    // One frame: centre set while vsync is high, falling edge, then garbage after the sample.
    task automatic frame(input int x, input int y);
        @(posedge clk); #2;
        center_x = 10'(x);
        center_y = 10'(y);
        vsync = 1'b1;
        repeat (2) @(posedge clk);
        #2 vsync = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        center_x = 10'd1023;
        center_y = 10'd1023;
        repeat (3) @(posedge clk);
    endtask

    task automatic frames(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) frame(x, y);
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        // Pin the reference decoder on the boundary points.
        chk("dec_x79",  mkey(79, 300), 0);
        chk("dec_x80",  mkey(80, 300), 1);
        chk("dec_x640", mkey(640, 300), 15);
        chk("dec_y239", mkey(200, 239), 15);
        chk("dec_y240", mkey(200, 240), 2);
        chk("dec_y479", mkey(200, 479), 2);

        repeat (3) @(posedge clk);
        settle();
        chk("rst_active", int'(key_active), 0);
        chk("rst_note_key", int'(note_key), 0);
        @(posedge clk); #2 reset = 1'b0;

        frames(0, 0, 2);
        settle();
        chk("idle_on_cnt", on_cnt, 0);

        // Press on key 2.
        frames(200, 300, 2);
        settle();
        chk("press_early", int'(key_active), 0);
        frame(200, 300);
        settle();
        chk("press_active", int'(key_active), 1);
        chk("press_idx", int'(key_idx), 2);
        chk("press_key", int'(note_key), 2);
        chk("press_on_cnt", on_cnt, 1);

        // One-frame glitch to key 7 does not release.
        frame(600, 300);
        frame(200, 300);
        settle();
        chk("glitch_off_cnt", off_cnt, 0);
        chk("glitch_idx", int'(key_idx), 2);

        // Slide to key 3.
        frame(280, 300);
        settle();
        chk("slide_f1_off", off_cnt, 0);
        frame(280, 300);
        settle();
        chk("slide_f2_off", off_cnt, 1);
        chk("slide_f2_key", int'(note_key), 2);
        chk("slide_f2_active", int'(key_active), 0);
        frame(280, 300);
        settle();
        chk("slide_f3_on", on_cnt, 1);
        frame(280, 300);
        settle();
        chk("slide_f4_on", on_cnt, 2);
        chk("slide_f4_key", int'(note_key), 3);
        chk("slide_f4_idx", int'(key_idx), 3);
        frame(280, 300);
        frames(0, 0, 2);
        settle();
        chk("release_off", off_cnt, 2);

        // Short press drops back to idle.
        frames(200, 300, 2);
        frame(200, 100);
        settle();
        chk("short_on", on_cnt, 2);
        chk("short_active", int'(key_active), 0);
        frames(200, 300, 2);
        settle();
        chk("short_rearm", int'(key_active), 0);
        frame(200, 300);
        settle();
        chk("short_press", int'(key_active), 1);
        chk("short_on2", on_cnt, 3);
        frames(0, 0, 2);

        // Horizontal boundaries.
        frames(79, 300, 3);
        settle();
        chk("x79_active", int'(key_active), 1);
        chk("x79_idx", int'(key_idx), 0);
        frames(0, 0, 2);
        frames(80, 300, 3);
        settle();
        chk("x80_idx", int'(key_idx), 1);
        frames(640, 300, 3);
        settle();
        chk("x640_active", int'(key_active), 0);
        chk("x640_off", off_cnt, 5);

        // Vertical boundaries.
        frames(200, 239, 3);
        settle();
        chk("y239_active", int'(key_active), 0);
        frames(200, 240, 3);
        settle();
        chk("y240_active", int'(key_active), 1);
        frame(200, 479);
        settle();
        chk("y479_idx", int'(key_idx), 2);
        chk("y479_off", off_cnt, 5);
        frames(0, 0, 2);

        // Reset while key 5 is held.
        frames(440, 300, 3);
        settle();
        chk("k5_idx", int'(key_idx), 5);
        @(posedge clk); #3 reset = 1'b1;
        #1;
        chk("rst_mid_active", int'(key_active), 0);
        chk("rst_mid_idx", int'(key_idx), 0);
        chk("rst_mid_note_key", int'(note_key), 0);
        center_x = 10'd440;
        center_y = 10'd300;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (20) @(posedge clk);
        settle();
        chk("rst_mid_off", off_cnt, 6);
        chk("post_rst_on", on_cnt, 7);
        chk("post_rst_active", int'(key_active), 0);
        frames(440, 300, 3);
        settle();
        chk("post_rst_press", int'(key_idx), 5);
        chk("post_rst_on2", on_cnt, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
